// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: select codes, FSM states,
// status-register bit positions and the op classification used at capture.
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_RSVD = 3'b011;
    localparam logic [2:0] OP_ANDN = 3'b100;
    localparam logic [2:0] OP_ORN  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    // Adder-based ops keep the ALU flags; logical ops get locally derived flags.
    function automatic logic is_arith(input logic [2:0] op);
        case (op)
            OP_AND, OP_OR, OP_ANDN, OP_ORN: return 1'b0;
            default:                        return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/alu_accum_seq_if.sv
// Command/response handshake bundle between a command source and the sequencer.
interface alu_accum_seq_if #(
    parameter int WIDTH = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_load;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_accum_seq.sv
// Accumulator-based sequencer feeding a combinational ALU: accepts one command,
// holds operands for SETTLE_CYCLES, captures result/flags, returns a response.
module alu_accum_seq
    import alu_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_accum_seq_if.slave   bus,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_n,
    input  logic             alu_v,
    input  logic             alu_z
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [3:0]       flags;
    logic [3:0]       cnt;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic             rsp_err_q;
    logic [3:0]       logic_flags;

    // The ALU's flags track its adder, so logical results need their own N/Z.
    always_comb begin
        logic_flags         = '0;
        logic_flags[FLAG_N] = alu_result[WIDTH-1];
        logic_flags[FLAG_Z] = (alu_result == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            acc         <= '0;
            alu_b       <= '0;
            alu_sel     <= OP_AND;
            flags       <= '0;
            cnt         <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        cmd_ready_q <= 1'b0;
                        if (bus.cmd_load) begin
                            acc         <= bus.cmd_data;
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else if (bus.cmd_op == OP_RSVD) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            alu_b     <= bus.cmd_data;
                            alu_sel   <= bus.cmd_op;
                            cnt       <= CNT_INIT;
                            rsp_err_q <= 1'b0;
                            state     <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        acc         <= alu_result;
                        flags       <= is_arith(alu_sel) ? {alu_c, alu_n, alu_v, alu_z}
                                                         : logic_flags;
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign alu_a         = acc;
    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = acc;
    assign bus.rsp_flags = flags;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_accum_seq.sv
// Directed bench: table of command/response vectors against a behavioural ALU,
// plus backpressure and mid-EXEC reset sequences.
module tb_alu_accum_seq;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    alu_accum_seq_if #(.WIDTH(8)) b1 ();
    alu_accum_seq_if #(.WIDTH(8)) b4 ();

    logic [7:0] a1, bop1, res1, a4, bop4, res4;
    logic [2:0] sel1, sel4;
    logic       c1, n1, v1, z1, c4, n4, v4, z4;

    alu_accum_seq #(.WIDTH(8), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1.slave),
        .alu_a(a1), .alu_b(bop1), .alu_sel(sel1), .alu_result(res1),
        .alu_c(c1), .alu_n(n1), .alu_v(v1), .alu_z(z1)
    );

    alu_accum_seq #(.WIDTH(8), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave),
        .alu_a(a4), .alu_b(bop4), .alu_sel(sel4), .alu_result(res4),
        .alu_c(c4), .alu_n(n4), .alu_v(v4), .alu_z(z4)
    );

    // Behavioural ALU: flags always come from the adder (a+b, or a-b for 1xx codes).
    function automatic logic [11:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] s);
        logic [8:0] sum;
        logic [7:0] bb, r;
        logic       v;
        bb  = s[2] ? ~b : b;
        sum = {1'b0, a} + {1'b0, bb} + {8'b0, s[2]};
        v   = (a[7] == bb[7]) && (sum[7] != a[7]);
        case (s)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b100:  r = a & ~b;
            3'b101:  r = a | ~b;
            3'b111:  r = {7'b0, sum[7] ^ v};
            3'b011:  r = 8'h00;
            default: r = sum[7:0];
        endcase
        return {sum[8], sum[7], v, (sum[7:0] == 8'h00), r};
    endfunction

    always_comb {c1, n1, v1, z1, res1} = alu_f(a1, bop1, sel1);
    always_comb {c4, n4, v4, z4, res4} = alu_f(a4, bop4, sel4);

    logic sel_bad = 1'b0;
    always @(negedge clk) if (sel1 == 3'b011 || sel4 == 3'b011) sel_bad <= 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue one command on b1 and return cycles from accept edge to rsp_valid.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [7:0] d,
                         output int lat);
        int n = 0;
        while (!b1.cmd_ready && n < 20) begin @(negedge clk); n++; end
        check("cmd_ready_before_issue", b1.cmd_ready, 1);
        b1.cmd_valid = 1'b1; b1.cmd_load = ld; b1.cmd_op = op; b1.cmd_data = d;
        @(posedge clk);
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        lat = 1;
        while (!b1.rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    endtask

    task automatic take_rsp();
        b1.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b1.rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic       ld;
        logic [2:0] op;
        logic [7:0] data;
        logic [7:0] exp_data;
        logic [3:0] exp_flags;
        logic       exp_err;
        int         exp_lat;
    } vec_t;

    vec_t vt[14];
    int   lat;

    initial begin
        vt[0]  = '{1'b1, 3'b000, 8'h7F, 8'h7F, 4'b0000, 1'b0, 1};
        vt[1]  = '{1'b0, 3'b010, 8'h01, 8'h80, 4'b0110, 1'b0, 2};
        vt[2]  = '{1'b1, 3'b000, 8'h35, 8'h35, 4'b0110, 1'b0, 1};
        vt[3]  = '{1'b0, 3'b110, 8'h35, 8'h00, 4'b1001, 1'b0, 2};
        vt[4]  = '{1'b1, 3'b000, 8'hF0, 8'hF0, 4'b1001, 1'b0, 1};
        vt[5]  = '{1'b0, 3'b000, 8'h0F, 8'h00, 4'b0001, 1'b0, 2};
        vt[6]  = '{1'b1, 3'b000, 8'h12, 8'h12, 4'b0001, 1'b0, 1};
        vt[7]  = '{1'b0, 3'b011, 8'h55, 8'h12, 4'b0001, 1'b1, 1};
        vt[8]  = '{1'b0, 3'b001, 8'h81, 8'h93, 4'b0100, 1'b0, 2};
        vt[9]  = '{1'b0, 3'b100, 8'h03, 8'h90, 4'b0100, 1'b0, 2};
        vt[10] = '{1'b0, 3'b101, 8'hF0, 8'h9F, 4'b0100, 1'b0, 2};
        vt[11] = '{1'b0, 3'b111, 8'h05, 8'h01, 4'b1100, 1'b0, 2};
        vt[12] = '{1'b0, 3'b010, 8'hFF, 8'h00, 4'b1001, 1'b0, 2};
        vt[13] = '{1'b0, 3'b110, 8'h01, 8'hFF, 4'b0100, 1'b0, 2};

        rst_n = 1'b1;
        b1.cmd_valid = 0; b1.cmd_load = 0; b1.cmd_op = 0; b1.cmd_data = 0; b1.rsp_ready = 0;
        b4.cmd_valid = 0; b4.cmd_load = 0; b4.cmd_op = 0; b4.cmd_data = 0; b4.rsp_ready = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", b1.cmd_ready, 0);
        check("rst_rsp_valid", b1.rsp_valid, 0);
        check("rst_rsp_data", b1.rsp_data, 0);
        check("rst_rsp_flags", b1.rsp_flags, 0);
        check("rst_rsp_err", b1.rsp_err, 0);
        check("rst_alu_b", bop1, 0);
        check("rst_alu_sel", sel1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("cmd_ready_after_reset", b1.cmd_ready, 1);
        check("cmd_ready_after_reset_s4", b4.cmd_ready, 1);

        for (int i = 0; i < 14; i++) begin
            issue(vt[i].ld, vt[i].op, vt[i].data, lat);
            check($sformatf("vec%0d_data", i), b1.rsp_data, vt[i].exp_data);
            check($sformatf("vec%0d_flags", i), b1.rsp_flags, vt[i].exp_flags);
            check($sformatf("vec%0d_err", i), b1.rsp_err, vt[i].exp_err);
            check($sformatf("vec%0d_latency", i), lat, vt[i].exp_lat);
            check($sformatf("vec%0d_alu_a", i), a1, vt[i].exp_data);
            take_rsp();
        end

        // Backpressure: acc=FF, ADD 02 -> 01 with C set; hold response 5 cycles.
        issue(1'b0, 3'b010, 8'h02, lat);
        check("bp_latency", lat, 2);
        b1.cmd_valid = 1'b1; b1.cmd_load = 1'b1; b1.cmd_data = 8'h55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", b1.rsp_valid, 1);
            check("bp_rsp_data", b1.rsp_data, 8'h01);
            check("bp_rsp_flags", b1.rsp_flags, 4'b1000);
            check("bp_cmd_ready", b1.cmd_ready, 0);
        end
        b1.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b1.rsp_ready = 1'b0;
        check("bp_after_hs_valid", b1.rsp_valid, 0);
        check("bp_after_hs_not_loaded", b1.rsp_data, 8'h01);
        check("bp_after_hs_ready", b1.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b1.cmd_valid = 1'b0;
        check("bp_second_cmd_valid", b1.rsp_valid, 1);
        check("bp_second_cmd_data", b1.rsp_data, 8'h55);
        take_rsp();

        // Mid-EXEC reset on the SETTLE_CYCLES=4 instance.
        b4.cmd_valid = 1'b1; b4.cmd_load = 1'b1; b4.cmd_data = 8'h44;
        @(posedge clk);
        @(negedge clk);
        b4.cmd_valid = 1'b0;
        check("s4_load_valid", b4.rsp_valid, 1);
        b4.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b4.rsp_ready = 1'b0;
        b4.cmd_valid = 1'b1; b4.cmd_load = 1'b0; b4.cmd_op = 3'b010; b4.cmd_data = 8'h11;
        @(posedge clk);
        @(negedge clk);
        b4.cmd_valid = 1'b0;
        check("s4_exec_alu_b", bop4, 8'h11);
        check("s4_exec_alu_a", a4, 8'h44);
        check("s4_exec_no_rsp", b4.rsp_valid, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s4_async_rsp_valid", b4.rsp_valid, 0);
        check("s4_async_cmd_ready", b4.cmd_ready, 0);
        check("s4_async_acc", b4.rsp_data, 0);
        check("s4_async_alu_a", a4, 0);
        check("s4_async_alu_b", bop4, 0);
        check("s4_async_alu_sel", sel4, 0);
        check("s4_async_flags", b4.rsp_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("s4_no_rsp_after_reset", b4.rsp_valid, 0);
        end
        check("s4_acc_after_reset", b4.rsp_data, 0);
        check("s4_ready_after_reset", b4.cmd_ready, 1);
        check("alu_sel_never_rsvd", sel_bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_accum_seq.md
Name: alu_accum_seq

Overview:
- Command sequencer directly upstream of the 8-bit ALU (ops: AND, OR, ADD, unused code 011, AND-NOT, OR-NOT, SUB, set-less-than).
- Accepts commands over a valid/ready handshake and holds an accumulator that drives ALU operand A. Drives operand B and the select code, waits for the combinational ALU to settle, then captures the result and C/N/V/Z into accumulator and status registers.
- Returns each result over a valid/ready response channel, so the datapath can be driven by a simple command stream.

Parameters:
- WIDTH, 8, datapath width; matches the ALU operand width.
- SETTLE_CYCLES, 1, cycles ALU inputs are held stable before capture (1..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_load  input  1  1 = load cmd_data into accumulator; no ALU op.
- cmd_op  input  3  ALU select code.
- cmd_data  input  WIDTH  operand B, or load value.
- alu_a  output  WIDTH  to ALU A; always equals the accumulator.
- alu_b  output  WIDTH  to ALU B; registered.
- alu_sel  output  3  to ALU Select; registered.
- alu_result  input  WIDTH  ALU Result.
- alu_c, alu_n, alu_v, alu_z  input  1 each  ALU adder flags.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  WIDTH  accumulator value after the command.
- rsp_flags  output  4  {C,N,V,Z} status register.
- rsp_err  output  1  command was illegal.

Behaviour:
- Reset (async, rst_n=0), applied immediately regardless of state:
  - state=IDLE; accumulator=0; alu_b=0; alu_sel=3'b000; flags=4'b0000; rsp_valid=0; rsp_err=0; settle counter=0.
  - cmd_ready=1 after the first clock edge with rst_n=1 (it is 0 while in reset).
  - A command or response in flight is discarded. No response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready=1.
  - On the edge with cmd_valid&cmd_ready, one of three cases applies:
    - cmd_load=1: acc<=cmd_data; flags unchanged; rsp_err<=0; go to RESP.
    - cmd_load=0 and cmd_op=3'b011: illegal. acc and flags unchanged; rsp_err<=1; go to RESP. The ALU is never driven with 011.
    - Otherwise: alu_b<=cmd_data; alu_sel<=cmd_op; counter<=SETTLE_CYCLES-1; rsp_err<=0; go to EXEC.
- EXEC:
  - cmd_ready=0.
  - While counter!=0: decrement each edge.
  - On the edge where counter==0: acc<=alu_result; go to RESP.
  - Flag capture depends on the select code:
    - Arithmetic ops (010, 110, 111): flags<={alu_c,alu_n,alu_v,alu_z}.
    - Logical ops (000, 001, 100, 101): C=0, V=0, N=alu_result[WIDTH-1], Z=(alu_result==0). These are computed locally, because the ALU flags reflect the adder and not the logical result.
- RESP:
  - rsp_valid=1; cmd_ready=0; rsp_data=acc; rsp_flags=flags.
  - rsp_data, rsp_flags and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
  - On the edge with rsp_ready=1: go to IDLE; rsp_valid<=0.
- Latency:
  - ALU command: accept edge T0; rsp_valid high from T0+SETTLE_CYCLES+1... precisely, from after edge T0+SETTLE_CYCLES. With default settings, rsp_valid is high in the cycle after the edge following acceptance.
  - Load and illegal commands: rsp_valid high after the accept edge.
- Throughput: one command is outstanding at a time. cmd_ready is never asserted in the same cycle as rsp_valid.
- Arithmetic: no width extension. Results are WIDTH bits and wrap modulo 2^WIDTH as produced by the ALU.
- alu_a changes only on load or capture edges, so it is stable throughout EXEC.

Decomposition:
- Shared package alu_pkg:
  - Select-code constants: OP_AND=000, OP_OR=001, OP_ADD=010, OP_RSVD=011, OP_ANDN=100, OP_ORN=101, OP_SUB=110, OP_SLT=111.
  - FSM state enum.
  - Flag bit index constants: C=3, N=2, V=1, Z=0.
- No sub-module is needed. A single module containing the FSM, accumulator and status register is natural.
- The bench instantiates the existing ALU beside it.

Test Plan:
- Load then add: load 8'h7F; ADD 8'h01 -> rsp_data=8'h80, rsp_flags V=1, N=1, Z=0, C=0; rsp_valid exactly 2 cycles after accept edge (SETTLE_CYCLES=1).
- Subtract to zero: load 8'h35; SUB 8'h35 -> rsp_data=8'h00, Z=1, rsp_err=0.
- Logical flag override: load 8'hF0; AND 8'h0F -> rsp_data=8'h00, flags=4'b0001 regardless of ALU adder flags.
- Illegal op: acc=8'h12, issue op 011 -> rsp_err=1, rsp_data=8'h12, flags unchanged, alu_sel never equals 011.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_data/rsp_flags stable, cmd_ready=0 throughout, a second cmd_valid is not accepted until 1 cycle after the handshake.
- Reset mid-EXEC (SETTLE_CYCLES=4): assert rst_n=0 during the 2nd settle cycle -> all outputs at reset values asynchronously, no rsp_valid afterwards, accumulator=0.
